// File: rtl/present_decrypt_core_pkg.sv
// ----------------------------------------------------------------------------
// present_pkg
// Shared definitions for the PRESENT-80 decryption core: S-box tables, block
// and key widths, the FSM state type and the key-schedule helper functions.
// No ports (package).
// ----------------------------------------------------------------------------
package present_pkg;

   localparam int ROUNDS  = 31;
   localparam int BLOCK_W = 64;
   localparam int KEY_W   = 80;

   localparam logic [3:0] SBOX [16] = '{
      4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
      4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
   };

   localparam logic [3:0] INV_SBOX [16] = '{
      4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
      4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
   };

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      KEYEXP = 3'd1,
      WHITEN = 3'd2,
      ROUND  = 3'd3,
      DONE   = 3'd4
   } fsm_state_t;

   // Forward PRESENT-80 key-register update for round counter rc.
   function automatic logic [KEY_W-1:0] key_update(input logic [KEY_W-1:0] k,
                                                   input logic [4:0]       rc);
      logic [KEY_W-1:0] t;
      t          = {k[18:0], k[79:19]};
      t[79:76]   = SBOX[t[79:76]];
      t[19:15]   = t[19:15] ^ rc;
      return t;
   endfunction

   // Undoes key_update for the same rc: K(rc) = inv_key_update(K(rc+1), rc).
   function automatic logic [KEY_W-1:0] inv_key_update(input logic [KEY_W-1:0] k,
                                                       input logic [4:0]       rc);
      logic [KEY_W-1:0] t;
      t          = k;
      t[19:15]   = t[19:15] ^ rc;
      t[79:76]   = INV_SBOX[t[79:76]];
      return {t[60:0], t[79:61]};
   endfunction

   // Inverse S-box applied to all 16 nibbles of the state.
   function automatic logic [BLOCK_W-1:0] inv_sbox_layer(input logic [BLOCK_W-1:0] s);
      logic [BLOCK_W-1:0] r;
      r = {BLOCK_W{1'b0}};
      for (int n = 0; n < 16; n++) begin
         r[4*n +: 4] = INV_SBOX[s[4*n +: 4]];
      end
      return r;
   endfunction

endpackage

// File: rtl/present_decrypt_core_if.sv
// ----------------------------------------------------------------------------
// present_decrypt_core_if
// Ciphertext/key offer handshake, plaintext result handshake and busy flag.
//   master : the producer/consumer side (drives inValid/inData/inKey/outReady)
//   slave  : the decryption core (drives inReady/outValid/outData/busy)
// ----------------------------------------------------------------------------
interface present_decrypt_core_if;
   import present_pkg::*;

   logic               inValid;
   logic               inReady;
   logic [BLOCK_W-1:0] inData;
   logic [KEY_W-1:0]   inKey;
   logic               outValid;
   logic               outReady;
   logic [BLOCK_W-1:0] outData;
   logic               busy;

   modport master (
      output inValid, inData, inKey, outReady,
      input  inReady, outValid, outData, busy
   );

   modport slave (
      input  inValid, inData, inKey, outReady,
      output inReady, outValid, outData, busy
   );

endinterface

// File: rtl/present_decrypt_core_inv_player.sv
// ----------------------------------------------------------------------------
// present_inv_player
// Combinational inverse PRESENT bit permutation.
//   din  [63:0] in  : state before the inverse permutation
//   dout [63:0] out : output bit j takes input bit 16*(j mod 4) + j/4
// ----------------------------------------------------------------------------
module present_inv_player (
   input  logic [63:0] din,
   output logic [63:0] dout
);

   for (genvar j = 0; j < 64; j++) begin : g_bit
      assign dout[j] = din[16*(j%4) + j/4];
   end

endmodule

// File: rtl/present_decrypt_core.sv
// ----------------------------------------------------------------------------
// present_decrypt_core
// Iterative PRESENT-80 block decryption, one round per clock.
//   clk   in : single clock, rising edge
//   rst_n in : asynchronous active-low reset
//   bus      : present_decrypt_core_if.slave
//              inValid/inReady/inData/inKey  - ciphertext + key offer
//              outValid/outReady/outData     - plaintext result (0 when idle)
//              busy                          - high outside IDLE
// Flow: IDLE -> KEYEXP (31 cycles, forward schedule up to K32) -> WHITEN
//       -> ROUND (31 cycles, inverse rounds, key walked back) -> DONE.
// Optional macro PRESENT_KEY_CACHE_EN: remembers the last user key and its
// K32 so a repeated key skips KEYEXP.
// ----------------------------------------------------------------------------
module present_decrypt_core #(
   parameter int ROUNDS = 31
) (
   input  logic                       clk,
   input  logic                       rst_n,
   present_decrypt_core_if.slave      bus
);
   import present_pkg::*;

   localparam logic [4:0] RC_LAST  = 5'(ROUNDS);
   localparam logic [4:0] RC_FIRST = 5'd1;

   fsm_state_t         state_r,  state_nxt_s;
   logic [BLOCK_W-1:0] data_r,   data_nxt_s;
   logic [KEY_W-1:0]   key_r,    key_nxt_s;
   logic [4:0]         rc_r,     rc_nxt_s;

   logic               in_ready_r;
   logic               out_valid_r;
   logic [BLOCK_W-1:0] out_data_r;
   logic               busy_r;

   logic               accept_s;
   logic               hit_s;
   logic [KEY_W-1:0]   cache_k32_s;
   logic [BLOCK_W-1:0] invp_s;
   logic [KEY_W-1:0]   kn_s;

   present_inv_player u_inv_player (
      .din  (data_r),
      .dout (invp_s)
   );

   // Offer is taken only while idle and advertising ready.
   always_comb begin
      accept_s = (state_r == IDLE) && in_ready_r && bus.inValid;
   end

   // Previous-round key, derived from the current key and round counter.
   always_comb begin
      kn_s = inv_key_update(key_r, rc_r);
   end

`ifdef PRESENT_KEY_CACHE_EN
   logic [KEY_W-1:0] cache_key_r;
   logic [KEY_W-1:0] cache_k32_r;
   logic             cache_valid_r;

   // Hit when the offered key matches the last fully expanded key.
   always_comb begin
      hit_s       = cache_valid_r && (bus.inKey == cache_key_r);
      cache_k32_s = cache_k32_r;
   end

   // Key tag captured on a missing accept; K32 and valid written when KEYEXP completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cache_key_r   <= {KEY_W{1'b0}};
         cache_k32_r   <= {KEY_W{1'b0}};
         cache_valid_r <= 1'b0;
      end else if (accept_s && !hit_s) begin
         cache_key_r   <= bus.inKey;
         cache_valid_r <= 1'b0;
      end else if ((state_r == KEYEXP) && (rc_r == RC_LAST)) begin
         cache_k32_r   <= key_nxt_s;
         cache_valid_r <= 1'b1;
      end else begin
         cache_valid_r <= cache_valid_r;
      end
   end
`else
   // Without the cache every block expands its key.
   always_comb begin
      hit_s       = 1'b0;
      cache_k32_s = {KEY_W{1'b0}};
   end
`endif

   // Next-state and datapath update.
   always_comb begin
      state_nxt_s = state_r;
      data_nxt_s  = data_r;
      key_nxt_s   = key_r;
      rc_nxt_s    = rc_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               data_nxt_s = bus.inData;
               rc_nxt_s   = RC_FIRST;
               if (hit_s) begin
                  key_nxt_s   = cache_k32_s;
                  state_nxt_s = WHITEN;
               end else begin
                  key_nxt_s   = bus.inKey;
                  state_nxt_s = KEYEXP;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         KEYEXP: begin
            key_nxt_s = key_update(key_r, rc_r);
            if (rc_r == RC_LAST) begin
               state_nxt_s = WHITEN;
            end else begin
               rc_nxt_s = rc_r + 5'd1;
            end
         end
         WHITEN: begin
            data_nxt_s  = data_r ^ key_r[79:16];
            rc_nxt_s    = RC_LAST;
            state_nxt_s = ROUND;
         end
         ROUND: begin
            data_nxt_s = inv_sbox_layer(invp_s) ^ kn_s[79:16];
            key_nxt_s  = kn_s;
            if (rc_r == RC_FIRST) begin
               state_nxt_s = DONE;
            end else begin
               rc_nxt_s = rc_r - 5'd1;
            end
         end
         DONE: begin
            if (out_valid_r && bus.outReady) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State, datapath and output registers; outputs are decoded from the next state
   // so they line up with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         data_r      <= {BLOCK_W{1'b0}};
         key_r       <= {KEY_W{1'b0}};
         rc_r        <= 5'd0;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         out_data_r  <= {BLOCK_W{1'b0}};
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         data_r      <= data_nxt_s;
         key_r       <= key_nxt_s;
         rc_r        <= rc_nxt_s;
         in_ready_r  <= (state_nxt_s == IDLE);
         out_valid_r <= (state_nxt_s == DONE);
         out_data_r  <= (state_nxt_s == DONE) ? data_nxt_s : {BLOCK_W{1'b0}};
         busy_r      <= (state_nxt_s != IDLE);
      end
   end

   assign bus.inReady  = in_ready_r;
   assign bus.outValid = out_valid_r;
   assign bus.outData  = out_data_r;
   assign bus.busy     = busy_r;

endmodule

// File: tb/tb_present_decrypt_core.sv
// ----------------------------------------------------------------------------
// tb_present_decrypt_core
// Bench for present_decrypt_core. Expected plaintexts come from known PRESENT-80
// vectors or from a forward-encryption model: random plaintext is encrypted
// here and the core must recover it. Latency is counted in cycles with the
// accept cycle as cycle 0 (outValid sampled on the falling edge).
// ----------------------------------------------------------------------------
module tb_present_decrypt_core;

   localparam logic [3:0] TB_SBOX [16] = '{
      4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
      4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
   };

   localparam int MISS_LAT = 64;
`ifdef PRESENT_KEY_CACHE_EN
   localparam int HIT_LAT  = 33;
`else
   localparam int HIT_LAT  = 64;
`endif

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;

   present_decrypt_core_if bus ();

   present_decrypt_core #(.ROUNDS(31)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // PRESENT-80 encryption straight from the cipher definition.
   function automatic logic [63:0] model_encrypt(input logic [63:0] pt, input logic [79:0] key_in);
      logic [79:0] k;
      logic [63:0] s;
      logic [63:0] p;
      k = key_in;
      s = pt;
      for (int r = 1; r <= 31; r++) begin
         s = s ^ k[79:16];
         for (int n = 0; n < 16; n++) s[4*n +: 4] = TB_SBOX[s[4*n +: 4]];
         p = 64'd0;
         for (int i = 0; i < 63; i++) p[(16*i) % 63] = s[i];
         p[63] = s[63];
         s = p;
         k = {k[18:0], k[79:19]};
         k[79:76] = TB_SBOX[k[79:76]];
         k[19:15] = k[19:15] ^ 5'(r);
      end
      return s ^ k[79:16];
   endfunction

   // Offer one block, wait for the result, then complete the output handshake.
   task automatic run_block(input logic [79:0] key, input logic [63:0] ct,
                            output logic [63:0] pt, output int lat);
      int guard;
      guard = 0;
      while (bus.inReady !== 1'b1 && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      bus.inKey   = key;
      bus.inData  = ct;
      bus.inValid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.inValid = 1'b0;
      bus.inData  = 64'd0;
      bus.inKey   = 80'd0;
      lat = 1;
      while (bus.outValid !== 1'b1 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      pt = bus.outData;
      bus.outReady = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.outReady = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (bus.inReady !== 1'b0) $display("FAIL reset_inReady got %0b want 0", bus.inReady); else n_pass++;
      n_checks++; if (bus.outValid !== 1'b0) $display("FAIL reset_outValid got %0b want 0", bus.outValid); else n_pass++;
      n_checks++; if (bus.outData !== 64'd0) $display("FAIL reset_outData got %h want 0", bus.outData); else n_pass++;
      n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", bus.busy); else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (bus.inReady !== 1'b1) $display("FAIL post_reset_inReady got %0b want 1", bus.inReady); else n_pass++;
      n_checks++; if (bus.busy !== 1'b0) $display("FAIL post_reset_busy got %0b want 0", bus.busy); else n_pass++;
   endtask

   task automatic test_vectors();
      logic [79:0] keys [4];
      logic [63:0] cts  [4];
      logic [63:0] pts  [4];
      logic [63:0] got;
      int          lat;
      keys = '{80'h0, {80{1'b1}}, 80'h0, {80{1'b1}}};
      cts  = '{64'h5579C1387B228445, 64'hE72C46C0F5945049, 64'hA112FFC72F68417B, 64'h3333DCD3213210D2};
      pts  = '{64'h0, 64'h0, {64{1'b1}}, {64{1'b1}}};
      for (int v = 0; v < 4; v++) begin
         run_block(keys[v], cts[v], got, lat);
         n_checks++; if (got !== pts[v]) $display("FAIL vector%0d_data got %h want %h", v + 1, got, pts[v]); else n_pass++;
         n_checks++; if (lat !== MISS_LAT) $display("FAIL vector%0d_latency got %0d want %0d", v + 1, lat, MISS_LAT); else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      logic [63:0] got;
      int          lat;
      int          cyc;
      bit          seen_valid;
      bus.inKey   = 80'd0;
      bus.inData  = 64'h5579C1387B228445;
      bus.inValid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.inValid = 1'b0;
      cyc = 1;
      seen_valid = (bus.outValid === 1'b1);
      // ROUND with rc=31 is cycle 33, so rc=15 is cycle 49.
      while (cyc < 49) begin
         @(negedge clk);
         cyc++;
         if (bus.outValid === 1'b1) seen_valid = 1'b1;
      end
      n_checks++; if (bus.busy !== 1'b1) $display("FAIL midrun_busy got %0b want 1", bus.busy); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++; if (bus.outValid !== 1'b0) $display("FAIL abort_outValid got %0b want 0", bus.outValid); else n_pass++;
      n_checks++; if (bus.outData !== 64'd0) $display("FAIL abort_outData got %h want 0", bus.outData); else n_pass++;
      n_checks++; if (bus.inReady !== 1'b0) $display("FAIL abort_inReady got %0b want 0", bus.inReady); else n_pass++;
      n_checks++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got %0b want 0", bus.busy); else n_pass++;
      n_checks++; if (seen_valid !== 1'b0) $display("FAIL abort_no_early_valid got %0b want 0", seen_valid); else n_pass++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (bus.inReady !== 1'b1) $display("FAIL after_abort_inReady got %0b want 1", bus.inReady); else n_pass++;
      run_block(80'd0, 64'h5579C1387B228445, got, lat);
      n_checks++; if (got !== 64'd0) $display("FAIL after_abort_data got %h want 0", got); else n_pass++;
      n_checks++; if (lat !== MISS_LAT) $display("FAIL after_abort_latency got %0d want %0d", lat, MISS_LAT); else n_pass++;
   endtask

   task automatic test_backpressure();
      logic [79:0] key;
      logic [63:0] pt;
      logic [63:0] held;
      int          lat;
      key = {16'($urandom), $urandom, $urandom};
      pt  = {$urandom, $urandom};
      bus.inKey   = key;
      bus.inData  = model_encrypt(pt, key);
      bus.inValid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.inValid = 1'b0;
      lat = 1;
      while (bus.outValid !== 1'b1 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      held = bus.outData;
      n_checks++; if (lat !== MISS_LAT) $display("FAIL bp_latency got %0d want %0d", lat, MISS_LAT); else n_pass++;
      n_checks++; if (held !== pt) $display("FAIL bp_data got %h want %h", held, pt); else n_pass++;
      // A competing offer while DONE must be ignored.
      bus.inKey   = {16'($urandom), $urandom, $urandom};
      bus.inData  = {$urandom, $urandom};
      bus.inValid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_checks++; if (bus.outValid !== 1'b1) $display("FAIL bp_valid_c%0d got %0b want 1", c, bus.outValid); else n_pass++;
         n_checks++; if (bus.outData !== pt) $display("FAIL bp_stable_c%0d got %h want %h", c, bus.outData, pt); else n_pass++;
         n_checks++; if (bus.inReady !== 1'b0) $display("FAIL bp_inReady_c%0d got %0b want 0", c, bus.inReady); else n_pass++;
      end
      bus.outReady = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.outReady = 1'b0;
      n_checks++; if (bus.inReady !== 1'b1) $display("FAIL bp_idle_inReady got %0b want 1", bus.inReady); else n_pass++;
      n_checks++; if (bus.outValid !== 1'b0) $display("FAIL bp_idle_outValid got %0b want 0", bus.outValid); else n_pass++;
      n_checks++; if (bus.outData !== 64'd0) $display("FAIL bp_idle_outData got %h want 0", bus.outData); else n_pass++;
      n_checks++; if (bus.busy !== 1'b0) $display("FAIL bp_idle_busy got %0b want 0", bus.busy); else n_pass++;
      bus.inValid = 1'b0;
   endtask

   task automatic test_random();
      logic [79:0] key;
      logic [63:0] pt;
      logic [63:0] got;
      int          lat;
      for (int t = 0; t < 6; t++) begin
         key = {16'($urandom), $urandom, $urandom};
         pt  = {$urandom, $urandom};
         run_block(key, model_encrypt(pt, key), got, lat);
         n_checks++; if (got !== pt) $display("FAIL random%0d_data got %h want %h", t, got, pt); else n_pass++;
         n_checks++; if (lat !== MISS_LAT) $display("FAIL random%0d_latency got %0d want %0d", t, lat, MISS_LAT); else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      logic [79:0] key;
      logic [63:0] pt;
      logic [63:0] got;
      int          lat;
      run_block(80'd0, 64'h5579C1387B228445, got, lat);
      n_checks++; if (got !== 64'd0) $display("FAIL b2b_first_data got %h want 0", got); else n_pass++;
      n_checks++; if (lat !== MISS_LAT) $display("FAIL b2b_first_latency got %0d want %0d", lat, MISS_LAT); else n_pass++;
      run_block(80'd0, 64'hA112FFC72F68417B, got, lat);
      n_checks++; if (got !== {64{1'b1}}) $display("FAIL b2b_repeat_data got %h want ffffffffffffffff", got); else n_pass++;
      n_checks++; if (lat !== HIT_LAT) $display("FAIL b2b_repeat_latency got %0d want %0d", lat, HIT_LAT); else n_pass++;
      key = {16'($urandom), $urandom, $urandom} | 80'd1;
      pt  = {$urandom, $urandom};
      run_block(key, model_encrypt(pt, key), got, lat);
      n_checks++; if (got !== pt) $display("FAIL b2b_newkey_data got %h want %h", got, pt); else n_pass++;
      n_checks++; if (lat !== MISS_LAT) $display("FAIL b2b_newkey_latency got %0d want %0d", lat, MISS_LAT); else n_pass++;
   endtask

   initial begin
      n_checks     = 0;
      n_pass       = 0;
      rst_n        = 1'b0;
      bus.inValid  = 1'b0;
      bus.inData   = 64'd0;
      bus.inKey    = 80'd0;
      bus.outReady = 1'b0;
      test_reset();
      test_vectors();
      test_reset_mid();
      test_backpressure();
      test_random();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/present_decrypt_core.md
PRESENT_DECRYPT_CORE -- requirements
Module: present_decrypt_core

Interface
REQ-001 Parameter: ROUNDS, 31, number of PRESENT rounds; only 31 is supported.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 inValid  in  1  ciphertext/key offer.
REQ-005 inReady  out  1  core accepts offer this cycle.
REQ-006 inData  in  64  ciphertext block.
REQ-007 inKey  in  80  PRESENT-80 user key.
REQ-008 outValid  out  1  plaintext available.
REQ-009 outReady  in  1  consumer accepts plaintext.
REQ-010 outData  out  64  plaintext block; stable while outValid=1.
REQ-011 busy  out  1  high in every state except IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, KEYEXP, WHITEN, ROUND and DONE.
REQ-013 IDLE: inReady=1; on inValid&inReady, latch inData into state and inKey into key register, set rc=1, go to KEYEXP.
REQ-014 KEYEXP, one cycle per rc=1..31: key = rotl61(key); key[79:76] = S(key[79:76]); key[19:15] ^= rc; rc++; after rc=31, go to WHITEN with key = K32.
REQ-015 WHITEN, 1 cycle: state ^= key[79:16]; rc=31; go to ROUND.
REQ-016 ROUND, one cycle per rc=31..1, computed from current registers:
  - kn = rotr61(Sinv-top-nibble(key ^ (rc<<15)));
  - state = invS(invP(state)) ^ kn[79:16]; key = kn; rc--;
  - after rc=1, go to DONE.
REQ-017 invP: input bit i moves to output bit j, where i = 16*(j mod 4) + floor(j/4); bits 0, 21, 42 and 63 are fixed.
REQ-018 invS applies the PRESENT inverse S-box to each of the 16 nibbles independently.
REQ-019 DONE: outValid=1 and outData=state; hold until outValid&outReady, then go to IDLE on the next cycle; no input is accepted in the same cycle.
REQ-020 Latency without cache hit: outValid asserts 64 cycles after the accept edge (1 load + 31 KEYEXP + 1 WHITEN + 31 ROUND).
REQ-021 inReady SHALL be 0 in all states except IDLE; inValid outside IDLE is ignored.
REQ-022 outData SHALL read 0 whenever outValid=0.
REQ-023 rc is a 5-bit register; no wrap occurs (range 1..31).

Reset
REQ-024 On rst_n=0, immediately:
  - state=IDLE; inReady=0 while in reset; outValid=0; outData=0; busy=0;
  - state, key and rc registers cleared; key cache invalidated.
REQ-025 Reset mid-KEYEXP, ROUND or DONE SHALL abort the block without emitting outValid.
REQ-026 After rst_n deasserts, inReady=1 from the first clock edge.

Configuration
REQ-027 Macro PRESENT_KEY_CACHE_EN:
  - When defined: the core stores the last user key and its K32 plus a valid bit. On accept with inKey equal to the stored key and valid=1, key is loaded with the cached K32 and the FSM goes directly to WHITEN, giving 33-cycle latency. Cache write occurs at the end of KEYEXP. Reset clears valid.
  - When undefined: no cache storage; every block runs KEYEXP and has 64-cycle latency.

Structure
REQ-028 Package present_pkg SHALL hold:
  - SBOX and INV_SBOX 16x4 constants;
  - ROUNDS, BLOCK_W=64 and KEY_W=80;
  - FSM state enum typedef;
  - inverse key-update function.
REQ-029 Inverse bit permutation SHALL be a separate combinational sub-module, present_inv_player (64 in, 64 out); the core instantiates it once.

Verification
REQ-030 Vector 1: key 0, ct 5579C1387B228445 -> outData 0000000000000000 at cycle 64.
REQ-031 Vector 2: key FFFFFFFFFFFFFFFFFFFF, ct E72C46C0F5945049 -> outData 0000000000000000.
REQ-032 Vectors 3 and 4:
  - key 0, ct A112FFC72F68417B -> FFFFFFFFFFFFFFFF;
  - key all-ones, ct 3333DCD3213210D2 -> FFFFFFFFFFFFFFFF.
REQ-033 Backpressure: hold outReady=0 for 10 cycles after outValid -> outData stable, inReady=0 throughout, IDLE one cycle after handshake.
REQ-034 Reset mid-operation: drop rst_n at ROUND rc=15 -> outputs 0 immediately, no outValid; next vector 1 decrypts correctly.
REQ-035 With PRESENT_KEY_CACHE_EN: vector 1 twice back-to-back -> second outValid 33 cycles after accept; new key -> 64 cycles.
